// File: rtl/prt_sched_pkg.sv
// Shared types for the PRT slot scheduler.
// Optional drop path selected by PRT_SCHED_DROP_EN.
package prt_sched_pkg;

  typedef enum logic [1:0] {
    S_FREE,
    S_FILLING,
    S_READY,
    S_SENDING
  } slot_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACTIVE
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_OFFER,
    T_BUSY
  } tx_state_t;

  localparam int ERR_W        = 3;
  localparam int ERR_RX_DONE  = 0;
  localparam int ERR_RX_ABORT = 1;
  localparam int ERR_TX_DONE  = 2;

endpackage

// File: rtl/prt_slot_scheduler_if.sv
// Receive/transmit handshake bundle of the PRT slot scheduler.
// rx_drop/drop_count exist only with PRT_SCHED_DROP_EN.
interface prt_slot_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic              rx_req;
  logic              rx_gnt;
  logic [SLOT_W-1:0] rx_slot;
  logic              rx_done;
  logic              rx_abort;
  logic              tx_valid;
  logic [SLOT_W-1:0] tx_slot;
  logic              tx_ready;
  logic              tx_done;
  logic [SLOT_W:0]   free_count;
  logic              slot_available;
  logic              proto_err;
`ifdef PRT_SCHED_DROP_EN
  logic              rx_drop;
  logic [15:0]       drop_count;
`endif

  modport master (
    input  rx_req, rx_done, rx_abort,
    input  tx_ready, tx_done,
`ifdef PRT_SCHED_DROP_EN
    input  rx_drop,
    output drop_count,
`endif
    output rx_gnt, rx_slot,
    output tx_valid, tx_slot,
    output free_count, slot_available,
    output proto_err
  );

  modport slave (
    output rx_req, rx_done, rx_abort,
    output tx_ready, tx_done,
`ifdef PRT_SCHED_DROP_EN
    output rx_drop,
    input  drop_count,
`endif
    input  rx_gnt, rx_slot,
    input  tx_valid, tx_slot,
    input  free_count, slot_available,
    input  proto_err
  );

endinterface

// File: rtl/prt_slot_fifo.sv
// Ready queue of slot indices in arrival order.
// Never overflows: it holds at most one entry per slot.
module prt_slot_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [AW:0]  count,
  output logic         empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/prt_slot_scheduler.sv
// PRT slot scheduler: explicit slot ownership for rx/tx.
// Define PRT_SCHED_DROP_EN for the rx_drop verdict path.
module prt_slot_scheduler
  import prt_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  prt_slot_scheduler_if.master bus
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  slot_state_t       slot_q [NUM_SLOTS];
  slot_state_t       slot_d [NUM_SLOTS];
  rx_state_t         rx_st_q, rx_st_d;
  tx_state_t         tx_st_q, tx_st_d;
  logic              rx_gnt_q, rx_gnt_d;
  logic [SLOT_W-1:0] rx_slot_q, rx_slot_d;
  logic              tx_valid_q, tx_valid_d;
  logic [SLOT_W-1:0] tx_slot_q, tx_slot_d;
  logic              proto_err_q, proto_err_d;
  logic [ERR_W-1:0]  cause;

  logic              free_hit;
  logic [SLOT_W-1:0] free_idx;
  logic [SLOT_W:0]   free_cnt;

  logic              fifo_push, fifo_pop;
  logic [SLOT_W-1:0] fifo_head;
  logic [SLOT_W:0]   fifo_cnt;
  logic              fifo_empty;
  logic              unused_fifo;

`ifdef PRT_SCHED_DROP_EN
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

  prt_slot_fifo #(
    .DEPTH (NUM_SLOTS),
    .W     (SLOT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (rx_slot_q),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign unused_fifo = ^fifo_cnt;

  // Descending scan leaves the lowest FREE index.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    free_cnt = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_q[i] == S_FREE) begin
        free_hit = 1'b1;
        free_idx = SLOT_W'(i);
        free_cnt = free_cnt + (SLOT_W+1)'(1);
      end
    end
  end

  always_comb begin
    slot_d     = slot_q;
    rx_st_d    = rx_st_q;
    rx_gnt_d   = 1'b0;
    rx_slot_d  = rx_slot_q;
    tx_st_d    = tx_st_q;
    tx_valid_d = tx_valid_q;
    tx_slot_d  = tx_slot_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    cause      = '0;
`ifdef PRT_SCHED_DROP_EN
    drop_cnt_d = drop_cnt_q;
`endif

    case (rx_st_q)
      R_ACTIVE: begin
        if (bus.rx_abort) begin
          slot_d[rx_slot_q] = S_FREE;
          rx_st_d           = R_IDLE;
        end else if (bus.rx_done) begin
          rx_st_d = R_IDLE;
`ifdef PRT_SCHED_DROP_EN
          if (bus.rx_drop) begin
            slot_d[rx_slot_q] = S_FREE;
            if (drop_cnt_q != 16'hFFFF)
              drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            slot_d[rx_slot_q] = S_READY;
            fifo_push         = 1'b1;
          end
`else
          slot_d[rx_slot_q] = S_READY;
          fifo_push         = 1'b1;
`endif
        end
      end
      default: begin
        cause[ERR_RX_DONE]  = bus.rx_done;
        cause[ERR_RX_ABORT] = bus.rx_abort;
        if (bus.rx_req && free_hit) begin
          slot_d[free_idx] = S_FILLING;
          rx_slot_d        = free_idx;
          rx_gnt_d         = 1'b1;
          rx_st_d          = R_ACTIVE;
        end
      end
    endcase

    case (tx_st_q)
      T_OFFER: begin
        cause[ERR_TX_DONE] = bus.tx_done;
        if (bus.tx_ready) begin
          fifo_pop          = 1'b1;
          slot_d[tx_slot_q] = S_SENDING;
          tx_valid_d        = 1'b0;
          tx_st_d           = T_BUSY;
        end
      end
      T_BUSY: begin
        if (bus.tx_done) begin
          slot_d[tx_slot_q] = S_FREE;
          tx_st_d           = T_IDLE;
        end
      end
      default: begin
        cause[ERR_TX_DONE] = bus.tx_done;
        if (!fifo_empty) begin
          tx_st_d    = T_OFFER;
          tx_valid_d = 1'b1;
          tx_slot_d  = fifo_head;
        end
      end
    endcase

    proto_err_d = |cause;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        slot_q[i] <= S_FREE;
      rx_st_q     <= R_IDLE;
      tx_st_q     <= T_IDLE;
      rx_gnt_q    <= 1'b0;
      rx_slot_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_slot_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      rx_st_q     <= rx_st_d;
      tx_st_q     <= tx_st_d;
      rx_gnt_q    <= rx_gnt_d;
      rx_slot_q   <= rx_slot_d;
      tx_valid_q  <= tx_valid_d;
      tx_slot_q   <= tx_slot_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef PRT_SCHED_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.rx_gnt         = rx_gnt_q;
  assign bus.rx_slot        = rx_slot_q;
  assign bus.tx_valid       = tx_valid_q;
  assign bus.tx_slot        = tx_slot_q;
  assign bus.free_count     = free_cnt;
  assign bus.slot_available = free_hit;
  assign bus.proto_err      = proto_err_q;

endmodule

// File: tb/tb_prt_slot_scheduler.sv
// Bench for prt_slot_scheduler: directed cases plus random traffic.
// Covers the PRT_SCHED_DROP_EN path when that macro is defined.
module tb_prt_slot_scheduler;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prt_slot_scheduler_if #(.NUM_SLOTS(N)) bus();

  prt_slot_scheduler #(.NUM_SLOTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t",
                 tag, got, exp, $time);
    end
  endtask

  // Reference: slot ownership as ints, ready queue as an SV queue.
  // slot: 0 free, 1 filling, 2 ready, 3 sending
  // tx phase: 0 idle, 1 offering, 2 transmitting
  int m_slot [N];
  int m_q [$];
  bit m_own;
  int m_rx_slot;
  bit m_gnt;
  int m_tx;
  int m_tx_slot;
  bit m_perr;
  int m_drops;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = 0;
    m_q.delete();
    m_own     = 0;
    m_rx_slot = 0;
    m_gnt     = 0;
    m_tx      = 0;
    m_tx_slot = 0;
    m_perr    = 0;
    m_drops   = 0;
  endtask

  task automatic model_edge();
    int pre_free;
    int pre_qn;
    bit drop;
    pre_free = -1;
    for (int i = N - 1; i >= 0; i--)
      if (m_slot[i] == 0) pre_free = i;
    pre_qn = m_q.size();
    drop = 0;
`ifdef PRT_SCHED_DROP_EN
    drop = bus.rx_drop;
`endif
    m_perr = ((bus.rx_done || bus.rx_abort) && !m_own)
          || (bus.tx_done && m_tx != 2);
    m_gnt = 0;
    case (m_tx)
      0: if (pre_qn > 0) begin
        m_tx      = 1;
        m_tx_slot = m_q[0];
      end
      1: if (bus.tx_ready) begin
        void'(m_q.pop_front());
        m_slot[m_tx_slot] = 3;
        m_tx = 2;
      end
      default: if (bus.tx_done) begin
        m_slot[m_tx_slot] = 0;
        m_tx = 0;
      end
    endcase
    if (!m_own) begin
      if (bus.rx_req && pre_free >= 0) begin
        m_slot[pre_free] = 1;
        m_rx_slot = pre_free;
        m_own = 1;
        m_gnt = 1;
      end
    end else if (bus.rx_abort) begin
      m_slot[m_rx_slot] = 0;
      m_own = 0;
    end else if (bus.rx_done) begin
      m_own = 0;
      if (drop) begin
        m_slot[m_rx_slot] = 0;
        if (m_drops < 65535) m_drops++;
      end else begin
        m_slot[m_rx_slot] = 2;
        m_q.push_back(m_rx_slot);
      end
    end
  endtask

  task automatic compare_all();
    int nf;
    nf = 0;
    for (int i = 0; i < N; i++)
      if (m_slot[i] == 0) nf++;
    check("rx_gnt", 32'(bus.rx_gnt), 32'(m_gnt));
    if (m_own)
      check("rx_slot", 32'(bus.rx_slot), m_rx_slot);
    check("tx_valid", 32'(bus.tx_valid), 32'(m_tx == 1));
    if (m_tx == 1)
      check("tx_slot", 32'(bus.tx_slot), m_tx_slot);
    check("free_count", 32'(bus.free_count), nf);
    check("slot_avail", 32'(bus.slot_available), 32'(nf != 0));
    check("proto_err", 32'(bus.proto_err), 32'(m_perr));
`ifdef PRT_SCHED_DROP_EN
    check("drop_count", 32'(bus.drop_count), m_drops);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.rx_req   = 0;
    bus.rx_done  = 0;
    bus.rx_abort = 0;
    bus.tx_ready = 0;
    bus.tx_done  = 0;
`ifdef PRT_SCHED_DROP_EN
    bus.rx_drop  = 0;
`endif
  endtask

  task automatic grant();
    int k;
    k = 0;
    bus.rx_req = 1;
    step();
    while (!bus.rx_gnt && k < 20) begin
      step();
      k++;
    end
    check("gnt_wait", 32'(bus.rx_gnt), 1);
    bus.rx_req = 0;
  endtask

  task automatic recv();
    grant();
    bus.rx_done = 1;
    step();
    bus.rx_done = 0;
  endtask

  task automatic accept(input int exp);
    int k;
    k = 0;
    while (!bus.tx_valid && k < 20) begin
      step();
      k++;
    end
    check("offer_wait", 32'(bus.tx_valid), 1);
    check("tx_order", 32'(bus.tx_slot), exp);
    bus.tx_ready = 1;
    step();
    bus.tx_ready = 0;
  endtask

  task automatic send(input int exp);
    accept(exp);
    bus.tx_done = 1;
    step();
    bus.tx_done = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},  32'(bus.rx_gnt), 0);
    check({tag, "_txv"},  32'(bus.tx_valid), 0);
    check({tag, "_rxs"},  32'(bus.rx_slot), 0);
    check({tag, "_txs"},  32'(bus.tx_slot), 0);
    check({tag, "_free"}, 32'(bus.free_count), N);
    check({tag, "_avl"},  32'(bus.slot_available), 1);
    check({tag, "_perr"}, 32'(bus.proto_err), 0);
`ifdef PRT_SCHED_DROP_EN
    check({tag, "_drop"}, 32'(bus.drop_count), 0);
`endif
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1;

    // first grant goes to slot 0 one cycle after the request
    bus.rx_req = 1;
    step();
    bus.rx_req = 0;
    check("first_gnt", 32'(bus.rx_gnt), 1);
    check("first_slot", 32'(bus.rx_slot), 0);
    check("first_free", 32'(bus.free_count), 3);
    bus.rx_done = 1;
    step();
    bus.rx_done = 0;

    // in-order queueing with the transmitter stalled
    recv();
    recv();
    step();
    check("head_valid", 32'(bus.tx_valid), 1);
    check("head_slot", 32'(bus.tx_slot), 0);
    send(0);
    send(1);
    send(2);
    step();
    check("drain_free", 32'(bus.free_count), N);

    // full pool: request waits until a slot is released
    for (int i = 0; i < N; i++) recv();
    bus.rx_req = 1;
    repeat (3) begin
      step();
      check("full_no_gnt", 32'(bus.rx_gnt), 0);
    end
    check("full_free", 32'(bus.free_count), 0);
    check("full_avl", 32'(bus.slot_available), 0);
    accept(0);
    bus.tx_done = 1;
    step();
    bus.tx_done = 0;
    check("refill_early", 32'(bus.rx_gnt), 0);
    step();
    check("refill_gnt", 32'(bus.rx_gnt), 1);
    check("refill_slot", 32'(bus.rx_slot), 0);
    bus.rx_req = 0;
    bus.rx_done = 1;
    step();
    bus.rx_done = 0;
    send(1);
    send(2);
    send(3);
    send(0);

    // abort beats done on slot 1 while slot 0 is transmitting
    recv();
    accept(0);
    grant();
    check("abort_slot", 32'(bus.rx_slot), 1);
    bus.rx_abort = 1;
    bus.rx_done  = 1;
    step();
    bus.rx_abort = 0;
    bus.rx_done  = 0;
    repeat (3) step();
    check("abort_txv", 32'(bus.tx_valid), 0);
    check("abort_free", 32'(bus.free_count), 3);
    bus.tx_done = 1;
    step();
    bus.tx_done = 0;
    step();

    // tx_done with nothing in flight
    bus.tx_done = 1;
    step();
    bus.tx_done = 0;
    check("perr_hi", 32'(bus.proto_err), 1);
    check("perr_free", 32'(bus.free_count), N);
    step();
    check("perr_lo", 32'(bus.proto_err), 0);

`ifdef PRT_SCHED_DROP_EN
    grant();
    bus.rx_drop = 1;
    bus.rx_done = 1;
    step();
    bus.rx_drop = 0;
    bus.rx_done = 0;
    check("drop_cnt", 32'(bus.drop_count), 1);
    repeat (3) step();
    check("drop_txv", 32'(bus.tx_valid), 0);
    check("drop_free", 32'(bus.free_count), N);
`endif

    // asynchronous reset in the middle of a receive
    recv();
    grant();
    #3;
    rst_n = 0;
    #1;
    check_reset_vals("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // random traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if (m_own) begin
        bus.rx_done  = ($urandom_range(0, 9) < 3);
        bus.rx_abort = ($urandom_range(0, 9) == 0);
      end else begin
        bus.rx_req  = ($urandom_range(0, 9) < 6);
        bus.rx_done = ($urandom_range(0, 39) == 0);
      end
`ifdef PRT_SCHED_DROP_EN
      bus.rx_drop = ($urandom_range(0, 9) < 3);
`endif
      bus.tx_ready = ($urandom_range(0, 1) == 1);
      if (m_tx == 2) bus.tx_done = ($urandom_range(0, 9) < 4);
      else           bus.tx_done = ($urandom_range(0, 39) == 0);
      step();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
